// File: rtl/dff_chk_pkg.sv
// Shared types for the dff_chk response checker: FSM state encoding and warm-up counter width.
package dff_chk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DUT_RST = 2'd1,
    WARM    = 2'd2,
    CHECK   = 2'd3
  } dff_chk_state_t;

  localparam int DFF_CHK_WARM_W = 4;

endpackage

// File: rtl/sat_cnt.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != '1)) q_d = q_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/dff_chk.sv
// Response checker for a D flip-flop: predicts q one cycle behind d and counts mismatches.
// Define DFF_CHK_FIRST_ERR_EN to capture chk_cnt and q_obs at the first mismatch.
module dff_chk
  import dff_chk_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int CNT_W  = 16,
  parameter int WARMUP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chk_en,
  input  logic             dut_rst_n,
  input  logic [WIDTH-1:0] d_obs,
  input  logic [WIDTH-1:0] q_obs,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic             busy,
  output logic [CNT_W-1:0] first_err_cyc,
  output logic [WIDTH-1:0] first_err_q,
  output dff_chk_state_t   dbg_state_o
);

  localparam logic [DFF_CHK_WARM_W-1:0] WARM_INIT = DFF_CHK_WARM_W'(WARMUP);
  localparam logic [DFF_CHK_WARM_W-1:0] WARM_ONE  = DFF_CHK_WARM_W'(1);

  dff_chk_state_t            state_q, state_d;
  logic [DFF_CHK_WARM_W-1:0] warm_q, warm_d;
  logic [WIDTH-1:0]          exp_q, exp_d;
  logic                      err_q, err_d;
  logic                      busy_q;
  logic                      do_chk, mismatch;

  // A low dut_rst_n outranks every state: that edge is judged by the reset rule (q must be 0).
  always_comb begin
    state_d  = state_q;
    warm_d   = warm_q;
    exp_d    = dut_rst_n ? d_obs : '0;
    do_chk   = 1'b0;
    mismatch = 1'b0;
    if (!dut_rst_n) begin
      if (state_q != IDLE) begin
        do_chk   = chk_en;
        mismatch = chk_en && (q_obs != '0);
      end
      state_d = DUT_RST;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        DUT_RST: begin
          if (WARMUP == 0) begin
            state_d = CHECK;
          end else begin
            state_d = WARM;
            warm_d  = WARM_INIT;
          end
        end
        WARM: begin
          if (warm_q == WARM_ONE) state_d = CHECK;
          else                    warm_d  = warm_q - WARM_ONE;
        end
        CHECK: begin
          do_chk   = chk_en;
          mismatch = chk_en && (q_obs != exp_q);
        end
        default: state_d = IDLE;
      endcase
    end
    err_d = err_q | mismatch;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      warm_q  <= '0;
      exp_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      busy_q  <= (state_d == CHECK);
    end
  end

  sat_cnt #(.W(CNT_W)) u_chk_cnt (
    .clk (clk),
    .rst (rst),
    .inc (do_chk),
    .q   (chk_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (mismatch),
    .q   (err_cnt)
  );

`ifdef DFF_CHK_FIRST_ERR_EN
  logic [CNT_W-1:0] fe_cyc_q;
  logic [WIDTH-1:0] fe_q_q;

  // chk_cnt here is the pre-increment value of the failing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      fe_cyc_q <= '0;
      fe_q_q   <= '0;
    end else if (mismatch && !err_q) begin
      fe_cyc_q <= chk_cnt;
      fe_q_q   <= q_obs;
    end
  end

  assign first_err_cyc = fe_cyc_q;
  assign first_err_q   = fe_q_q;
`else
  assign first_err_cyc = '0;
  assign first_err_q   = '0;
`endif

  assign err         = err_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dff_chk.sv
// Bench for dff_chk: a behavioural DFF drives two checker instances (WARMUP=1/CNT_W=16, WARMUP=2/CNT_W=4).
module tb_dff_chk;
  import dff_chk_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       chk_en = 1'b1;
  logic       dut_rst_n = 1'b1;
  logic [0:0] d_obs = 1'b0;
  logic [0:0] q_obs;
  logic [0:0] dff_q;
  int         mode = 0;  // 0 good DFF, 1 q stuck at 1 during reset, 2 inverted q

  logic        a_err, a_busy, b_err, b_busy;
  logic [15:0] a_err_cnt, a_chk_cnt, a_fe_cyc;
  logic [3:0]  b_err_cnt, b_chk_cnt, b_fe_cyc;
  logic [0:0]  a_fe_q, b_fe_q;
  dff_chk_state_t a_state, b_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge dut_rst_n) begin
    if (!dut_rst_n) dff_q <= 1'b0;
    else            dff_q <= d_obs;
  end

  always_comb begin
    q_obs = dff_q;
    if (mode == 1 && !dut_rst_n) q_obs = 1'b1;
    if (mode == 2)               q_obs = ~dff_q;
  end

  dff_chk #(.WIDTH(1), .CNT_W(16), .WARMUP(1)) u_a (
    .clk(clk), .rst(rst), .chk_en(chk_en), .dut_rst_n(dut_rst_n),
    .d_obs(d_obs), .q_obs(q_obs), .err(a_err), .err_cnt(a_err_cnt),
    .chk_cnt(a_chk_cnt), .busy(a_busy), .first_err_cyc(a_fe_cyc),
    .first_err_q(a_fe_q), .dbg_state_o(a_state)
  );

  dff_chk #(.WIDTH(1), .CNT_W(4), .WARMUP(2)) u_b (
    .clk(clk), .rst(rst), .chk_en(chk_en), .dut_rst_n(dut_rst_n),
    .d_obs(d_obs), .q_obs(q_obs), .err(b_err), .err_cnt(b_err_cnt),
    .chk_cnt(b_chk_cnt), .busy(b_busy), .first_err_cyc(b_fe_cyc),
    .first_err_q(b_fe_q), .dbg_state_o(b_state)
  );

  // Model: counts edges since the DUT came out of reset; q must be 0 in reset, d(prev) afterwards.
  typedef struct {
    bit   known;
    int   since;
    int   chk;
    int   errs;
    bit   errf;
    int   fe_cyc;
    int   fe_q;
    logic d_prev;
    bit   busy;
  } model_t;

  model_t ma, mb;

  function automatic int sat(int v, int m);
    return (v > m) ? m : v;
  endfunction

  function automatic model_t mstep(model_t m, int warmup, int maxc,
                                   logic r, logic rn, logic en, logic d, logic q);
    model_t n = m;
    bit cmp = 0;
    bit bad = 0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    if (!rn) begin
      if (m.known && en) begin
        cmp = 1;
        bad = (q != 1'b0);
      end
      n.known = 1;
      n.since = -1;
    end else if (m.known) begin
      if (m.since < 0) begin
        n.since = 0;
      end else begin
        n.since = m.since + 1;
        if (n.since > warmup && en) begin
          cmp = 1;
          bad = (q != m.d_prev);
        end
      end
    end
    if (bad && !m.errf) begin
      n.fe_cyc = sat(m.chk, maxc);
      n.fe_q   = int'(q);
    end
    if (cmp) n.chk++;
    if (bad) begin
      n.errs++;
      n.errf = 1;
    end
    n.d_prev = d;
    n.busy   = n.known && (rn == 1'b1) && (n.since >= warmup);
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    ma = mstep(ma, 1, 65535, rst, dut_rst_n, chk_en, d_obs[0], q_obs[0]);
    mb = mstep(mb, 2, 15,    rst, dut_rst_n, chk_en, d_obs[0], q_obs[0]);
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("a_err",     64'(a_err),     64'(ma.errf));
      check("a_err_cnt", 64'(a_err_cnt), 64'(sat(ma.errs, 65535)));
      check("a_chk_cnt", 64'(a_chk_cnt), 64'(sat(ma.chk, 65535)));
      check("a_busy",    64'(a_busy),    64'(ma.busy));
      check("b_err",     64'(b_err),     64'(mb.errf));
      check("b_err_cnt", 64'(b_err_cnt), 64'(sat(mb.errs, 15)));
      check("b_chk_cnt", 64'(b_chk_cnt), 64'(sat(mb.chk, 15)));
      check("b_busy",    64'(b_busy),    64'(mb.busy));
`ifdef DFF_CHK_FIRST_ERR_EN
      check("a_fe_cyc", 64'(a_fe_cyc), 64'(ma.fe_cyc));
      check("a_fe_q",   64'(a_fe_q),   64'(ma.fe_q));
      check("b_fe_cyc", 64'(b_fe_cyc), 64'(mb.fe_cyc));
      check("b_fe_q",   64'(b_fe_q),   64'(mb.fe_q));
`else
      check("a_fe_cyc", 64'(a_fe_cyc), 64'd0);
      check("a_fe_q",   64'(a_fe_q),   64'd0);
`endif
    end
  end

  // One clock edge with the given inputs; returns 1 time unit after the edge.
  task automatic step(input logic r, input logic rn, input logic en, input logic d, input int md);
    rst       = r;
    dut_rst_n = rn;
    chk_en    = en;
    d_obs     = d;
    mode      = md;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    cmp_on = 1;
    check("rst_err", 64'(a_err), 64'd0);
    check("rst_err_cnt", 64'(a_err_cnt), 64'd0);
    check("rst_chk_cnt", 64'(a_chk_cnt), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_state", 64'(a_state), 64'(IDLE));

    // Reference DFF: 3 reset edges, 60 running edges with d toggling every 5
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 60; i++) step(0, 1, 1, 1'((i / 5) % 2), 0);
    check("ref_chk_cnt", 64'(a_chk_cnt), 64'd60);
    check("ref_err_cnt", 64'(a_err_cnt), 64'd0);
    check("ref_err", 64'(a_err), 64'd0);
    check("ref_busy", 64'(a_busy), 64'd1);
    check("ref_b_chk_sat", 64'(b_chk_cnt), 64'd15);

    // q stuck at 1 during DUT reset
    step(1, 1, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    check("stuck_idle_err", 64'(a_err), 64'd0);
    step(0, 0, 1, 0, 1);
    check("stuck_err_latency", 64'(a_err), 64'd1);
    check("stuck_err_cnt1", 64'(a_err_cnt), 64'd1);
    step(0, 0, 1, 0, 1);
    check("stuck_err_cnt2", 64'(a_err_cnt), 64'd2);
    check("stuck_chk_cnt", 64'(a_chk_cnt), 64'd2);
`ifdef DFF_CHK_FIRST_ERR_EN
    check("stuck_fe_q", 64'(a_fe_q), 64'd1);
    check("stuck_fe_cyc", 64'(a_fe_cyc), 64'd0);
`endif

    // Inverted q: 10 then 20 checked edges; CNT_W=4 instance saturates
    step(1, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 2);
    step(0, 1, 1, 1, 2);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 1'(i % 2), 2);
    check("inv_err_cnt", 64'(a_err_cnt), 64'd10);
    check("inv_chk_cnt", 64'(a_chk_cnt), 64'd10);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 1'(i % 3 == 0), 2);
    check("inv_err_cnt20", 64'(a_err_cnt), 64'd20);
    check("sat_b_err_cnt", 64'(b_err_cnt), 64'd15);
    check("sat_b_chk_cnt", 64'(b_chk_cnt), 64'd15);

    // Mid-run DUT reset pulse of 2 edges after 20 good checks
    step(1, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 1'((i >> 1) & 1), 0);
    check("mid_chk20", 64'(a_chk_cnt), 64'd20);
    step(0, 0, 1, 1, 0);
    check("mid_state_rst", 64'(a_state), 64'(DUT_RST));
    check("mid_busy_rst", 64'(a_busy), 64'd0);
    step(0, 0, 1, 1, 0);
    check("mid_chk22", 64'(a_chk_cnt), 64'd22);
    step(0, 1, 1, 1, 0);
    check("mid_state_warm", 64'(a_state), 64'(WARM));
    step(0, 1, 1, 0, 0);
    check("mid_state_check", 64'(a_state), 64'(CHECK));
    check("mid_chk_hold", 64'(a_chk_cnt), 64'd22);
    step(0, 1, 1, 1, 0);
    check("mid_chk23", 64'(a_chk_cnt), 64'd23);
    check("mid_no_false_err", 64'(a_err), 64'd0);

    // chk_en low over mismatching edges, then matching data re-enabled
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1'(i % 2), 2);
    check("dis_chk_hold", 64'(a_chk_cnt), 64'd23);
    check("dis_err_hold", 64'(a_err_cnt), 64'd0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 1'(i % 2), 0);
    check("reen_chk", 64'(a_chk_cnt), 64'd28);
    check("reen_err", 64'(a_err), 64'd0);

    // rst and DUT reset on the same edge: rst wins
    step(1, 0, 1, 0, 0);
    check("both_state", 64'(a_state), 64'(IDLE));
    step(0, 0, 1, 0, 0);
    check("both_next_state", 64'(a_state), 64'(DUT_RST));
    check("both_no_cnt", 64'(a_chk_cnt), 64'd0);
    step(0, 0, 1, 0, 0);
    check("both_cnt1", 64'(a_chk_cnt), 64'd1);

    // DUT reset falling in CHECK with q_obs=1 and exp=1: judged by the reset rule
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0);
    check("fall_pre_err", 64'(a_err_cnt), 64'd0);
    step(0, 0, 1, 1, 2);
    check("fall_rule_err", 64'(a_err_cnt), 64'd1);
    step(0, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
